// File: rtl/ov_pkt_pkg.sv
// Shared types and constants for the event packetizer slice.
// Pure definitions; no logic, no latency, no flow control.
package ov_pkt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OVF  = 2'd1,
      ST_EVT  = 2'd2
   } state_t;

   localparam int EVT_PKT_LEN = 8;
   localparam int OVF_PKT_LEN = 2;

   localparam logic [3:0] MAGIC_DEF     = 4'hA;
   localparam logic [7:0] OVF_MAGIC_DEF = 8'hF0;

   typedef struct packed {
      logic [1:0]  ev_type;
      logic [23:0] addr;
      logic [15:0] data;
      logic [15:0] ts;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/event_queue.sv
// Synchronous FIFO, combinational head read; push while full is taken when a pop
// frees the slot in the same cycle. No internal backpressure beyond full/empty.
module event_queue #(
   parameter int WIDTH = 58,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_dat_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop    = pop_i && !empty_o;
   assign do_push   = push_i && (!full_o || do_pop);
   assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

   assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
      end
   end

endmodule

// File: rtl/event_packetizer.sv
// Timestamps sniffer events and serializes them into 8-byte packets; first byte 2 cycles
// after ev_valid. Packets start only on have_space; events hitting a full queue are counted.
module event_packetizer
   import ov_pkt_pkg::*;
#(
   parameter int         QUEUE_DEPTH = 4,
   parameter logic [3:0] MAGIC       = MAGIC_DEF,
   parameter logic [7:0] OVF_MAGIC   = OVF_MAGIC_DEF
) (
   input  logic        mclk,
   input  logic        reset,
   input  logic        ev_valid,
   input  logic [1:0]  ev_type,
   input  logic [23:0] ev_addr,
   input  logic [15:0] ev_data,
   input  logic        have_space,
   output logic [7:0]  data,
   output logic        wr,
   output logic [7:0]  drop_count
);

   localparam logic [2:0] EVT_LAST = 3'(EVT_PKT_LEN - 1);
   localparam logic [2:0] OVF_LAST = 3'(OVF_PKT_LEN - 1);

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [63:0] shreg_q, shreg_d;
   logic [7:0]  data_q, data_d;
   logic        wr_q, wr_d;
   logic [7:0]  drop_q, drop_d;
   logic [15:0] ts_q;

   entry_t      q_in, q_head;
   logic        q_full, q_empty, q_pop;
   logic        ovf_start, ev_drop;
   logic [63:0] evt_pkt;

   assign q_in    = '{ev_type: ev_type, addr: ev_addr, data: ev_data, ts: ts_q};
   assign evt_pkt = {MAGIC, q_head.ev_type, 2'b00, q_head.ts, q_head.addr, q_head.data};
   assign ev_drop = ev_valid && q_full && !q_pop;

   event_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk_i      (mclk),
      .reset_i    (reset),
      .push_i     (ev_valid),
      .push_dat_i (q_in),
      .pop_i      (q_pop),
      .pop_dat_o  (q_head),
      .full_o     (q_full),
      .empty_o    (q_empty)
   );

   // The IDLE decision also runs in the cycle the last byte is on the port, keeping packets contiguous.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      wr_d      = 1'b0;
      q_pop     = 1'b0;
      ovf_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (have_space) begin
               if (drop_q != 8'd0) begin
                  ovf_start = 1'b1;
                  state_d   = ST_OVF;
                  idx_d     = 3'd1;
                  data_d    = OVF_MAGIC;
                  shreg_d   = {drop_q, 56'd0};
                  wr_d      = 1'b1;
               end else if (!q_empty) begin
                  q_pop   = 1'b1;
                  state_d = ST_EVT;
                  idx_d   = 3'd1;
                  data_d  = evt_pkt[63:56];
                  shreg_d = {evt_pkt[55:0], 8'd0};
                  wr_d    = 1'b1;
               end
            end
         end
         ST_OVF, ST_EVT: begin
            wr_d    = 1'b1;
            data_d  = shreg_q[63:56];
            shreg_d = {shreg_q[55:0], 8'd0};
            idx_d   = idx_q + 3'd1;
            if (idx_q == ((state_q == ST_OVF) ? OVF_LAST : EVT_LAST)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      drop_d = drop_q;
      if (ovf_start) begin
         drop_d = {7'd0, ev_drop};
      end else if (ev_drop && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         shreg_q <= 64'd0;
         data_q  <= 8'd0;
         wr_q    <= 1'b0;
         drop_q  <= 8'd0;
         ts_q    <= 16'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         drop_q  <= drop_d;
         ts_q    <= ts_q + 16'd1;
      end
   end

   assign data       = data_q;
   assign wr         = wr_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_event_packetizer.sv
// Bench for event_packetizer: byte-stream reference model plus directed literal checks.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_event_packetizer;

   localparam int DEPTH = 4;

   logic        mclk = 1'b0;
   logic        reset = 1'b1;
   logic        ev_valid = 1'b0;
   logic [1:0]  ev_type = '0;
   logic [23:0] ev_addr = '0;
   logic [15:0] ev_data = '0;
   logic        have_space = 1'b0;
   logic [7:0]  data;
   logic        wr;
   logic [7:0]  drop_count;

   always #5 mclk = ~mclk;

   event_packetizer #(.QUEUE_DEPTH(DEPTH)) dut (
      .mclk       (mclk),
      .reset      (reset),
      .ev_valid   (ev_valid),
      .ev_type    (ev_type),
      .ev_addr    (ev_addr),
      .ev_data    (ev_data),
      .have_space (have_space),
      .data       (data),
      .wr         (wr),
      .drop_count (drop_count)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // Reference model: queued events become byte lists; one byte leaves per cycle.
   logic [63:0] m_q[$];
   logic [7:0]  m_pend[$];
   int          m_drops = 0;
   int          m_ts = 0;
   logic        m_wr = 1'b0;
   logic [7:0]  m_data = 8'd0;
   bit          m_data_known = 1'b1;
   logic [63:0] m_pkt;

   always @(posedge mclk) begin
      cyc++;
      if (reset) begin
         m_q.delete();
         m_pend.delete();
         m_drops = 0;
         m_ts = 0;
         m_wr = 1'b0;
         m_data = 8'd0;
         m_data_known = 1'b1;
      end else begin
         if (m_pend.size() == 0 && have_space) begin
            if (m_drops != 0) begin
               m_pend.push_back(8'hF0);
               m_pend.push_back(8'(m_drops));
               m_drops = 0;
            end else if (m_q.size() > 0) begin
               m_pkt = m_q.pop_front();
               for (int i = 0; i < 8; i++) m_pend.push_back(m_pkt[63-8*i -: 8]);
            end
         end
         if (ev_valid) begin
            if (m_q.size() < DEPTH)
               m_q.push_back({4'hA, ev_type, 2'b00, 16'(m_ts), ev_addr, ev_data});
            else if (m_drops < 255)
               m_drops++;
         end
         m_ts = (m_ts + 1) % 65536;
         if (m_pend.size() > 0) begin
            m_wr = 1'b1;
            m_data = m_pend.pop_front();
            m_data_known = 1'b1;
         end else begin
            m_wr = 1'b0;
            m_data_known = 1'b0;
         end
      end
   end

   logic [7:0] cap_dat[$];
   int         cap_cyc[$];

   always @(negedge mclk) begin
      if (chk_en) begin
         n_cmp++;
         if (wr !== m_wr) begin
            n_bad++;
            $display("FAIL wr cyc=%0d: got %b want %b", cyc, wr, m_wr);
         end
         if (m_data_known) begin
            n_cmp++;
            if (data !== m_data) begin
               n_bad++;
               $display("FAIL data cyc=%0d: got %02h want %02h", cyc, data, m_data);
            end
         end
         n_cmp++;
         if (drop_count !== 8'(m_drops)) begin
            n_bad++;
            $display("FAIL drop_count cyc=%0d: got %0d want %0d", cyc, drop_count, m_drops);
         end
      end
      if (wr === 1'b1) begin
         cap_dat.push_back(data);
         cap_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] cap_at(input int i);
      if (i < cap_dat.size()) return {24'd0, cap_dat[i]};
      return 32'hDEAD;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ev_valid = 1'b0;
      step(2);
      reset = 1'b0;
   endtask

   task automatic set_ev(input logic [1:0] t, input logic [23:0] a, input logic [15:0] d);
      ev_valid = 1'b1;
      ev_type = t;
      ev_addr = a;
      ev_data = d;
   endtask

   task automatic clear_cap();
      cap_dat.delete();
      cap_cyc.delete();
   endtask

   int n0;
   logic [7:0] exp1[8];

   initial begin
      do_reset();
      chk_en = 1'b1;
      chk("reset wr", wr, 0);
      chk("reset data", data, 0);
      chk("reset drop_count", drop_count, 0);

      // single event at ts=0x0010
      have_space = 1'b1;
      clear_cap();
      step(16);
      n0 = cyc;
      set_ev(2'd2, 24'h123456, 16'hBEEF);
      step(1);
      ev_valid = 1'b0;
      step(12);
      exp1 = '{8'hA8, 8'h00, 8'h10, 8'h12, 8'h34, 8'h56, 8'hBE, 8'hEF};
      chk("single len", cap_dat.size(), 8);
      chk("single first cycle", (cap_cyc.size() > 0) ? cap_cyc[0] - n0 : -1, 2);
      for (int i = 0; i < 8; i++) chk($sformatf("single byte%0d", i), cap_at(i), exp1[i]);

      // six back-to-back events: one dropped, overflow reported at the next decision
      clear_cap();
      for (int i = 0; i < 6; i++) begin
         set_ev(2'(i), 24'(i * 24'h010101), 16'(16'h1000 + i));
         step(1);
      end
      ev_valid = 1'b0;
      step(60);
      chk("burst len", cap_dat.size(), 42);
      chk("burst ovf hdr", cap_at(8), 8'hF0);
      chk("burst ovf cnt", cap_at(9), 8'h01);
      chk("burst contiguous", (cap_cyc.size() == 42) ? cap_cyc[41] - cap_cyc[0] : -1, 41);

      // have_space low: 4 queued, 3 dropped
      have_space = 1'b0;
      clear_cap();
      for (int i = 0; i < 7; i++) begin
         set_ev(2'd1, 24'(24'hA00000 + i), 16'(i));
         step(1);
      end
      ev_valid = 1'b0;
      step(5);
      chk("held no wr", cap_dat.size(), 0);
      chk("held drop_count", drop_count, 3);
      have_space = 1'b1;
      step(50);
      chk("held release len", cap_dat.size(), 34);
      chk("held ovf hdr", cap_at(0), 8'hF0);
      chk("held ovf cnt", cap_at(1), 8'h03);

      // saturation
      have_space = 1'b0;
      do_reset();
      clear_cap();
      for (int i = 0; i < 300; i++) begin
         set_ev(2'(i), 24'(i), 16'(i));
         step(1);
      end
      ev_valid = 1'b0;
      step(2);
      chk("sat drop_count", drop_count, 8'hFF);
      have_space = 1'b1;
      step(50);
      chk("sat ovf hdr", cap_at(0), 8'hF0);
      chk("sat ovf cnt", cap_at(1), 8'hFF);

      // reset in the middle of a packet
      do_reset();
      clear_cap();
      set_ev(2'd1, 24'hABCDEF, 16'h1234);
      step(1);
      ev_valid = 1'b0;
      step(4);
      chk("abort bytes before reset", cap_dat.size(), 3);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("abort wr", wr, 0);
      chk("abort data", data, 0);
      chk("abort drop_count", drop_count, 0);
      clear_cap();
      step(2);
      set_ev(2'd3, 24'h000001, 16'h0002);
      step(1);
      ev_valid = 1'b0;
      step(12);
      exp1 = '{8'hAC, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02};
      chk("post-reset len", cap_dat.size(), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("post-reset byte%0d", i), cap_at(i), exp1[i]);

      // timestamp wrap
      do_reset();
      clear_cap();
      step(16'hFFFF);
      for (int i = 0; i < 2; i++) begin
         set_ev(2'd0, 24'h0, 16'h0);
         step(1);
      end
      ev_valid = 1'b0;
      step(24);
      chk("wrap len", cap_dat.size(), 16);
      chk("wrap ts0 hi", cap_at(1), 8'hFF);
      chk("wrap ts0 lo", cap_at(2), 8'hFF);
      chk("wrap ts1 hi", cap_at(9), 8'h00);
      chk("wrap ts1 lo", cap_at(10), 8'h00);

      // randomized traffic with varying load and space
      for (int i = 0; i < 3000; i++) begin
         have_space = ($urandom_range(0, 3) != 0);
         ev_valid   = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 10 : 40));
         ev_type    = 2'($urandom);
         ev_addr    = 24'($urandom);
         ev_data    = 16'($urandom);
         step(1);
      end
      ev_valid = 1'b0;
      have_space = 1'b1;
      step(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
